// File: rtl/mod_n_down_timer.sv
// Loadable mod-N down-counter/timer. count, busy and tc are registered; tc pulses one clk at terminal count.
// Latency: count==load_val one cycle after start; tc N enabled cycles after start. No backpressure (en is a tick, not a handshake).
// Optional AUTO_RELOAD_EN: periodic mode reloads the latched period at terminal count instead of returning to IDLE.
module mod_n_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             terminal;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
`endif

    // count==0 cannot coexist with RUN; treating it as terminal keeps the counter from wrapping.
    assign terminal = (count_q <= ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= ZERO;
        end else begin
            period_q <= period_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef AUTO_RELOAD_EN
        period_d = period_q;
`endif

        if (abort) begin
            state_d = IDLE;
            count_d = ZERO;
        end else if (start) begin
`ifdef AUTO_RELOAD_EN
            period_d = load_val;
`endif
            if (load_val == ZERO) begin
                // Zero-length run: immediate terminal count, never enters RUN.
                tc_d    = 1'b1;
                count_d = ZERO;
                state_d = IDLE;
            end else begin
                count_d = load_val;
                state_d = RUN;
            end
        end else if ((state_q == RUN) && en) begin
            if (terminal) begin
                tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (period_q == ZERO) begin
                    count_d = ZERO;
                    state_d = IDLE;
                end else begin
                    count_d = period_q;
                    state_d = RUN;
                end
`else
                count_d = ZERO;
                state_d = IDLE;
`endif
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = tc_q;

endmodule
